// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - MEM-stage store/load and data_memory port bundle for the store buffer
interface store_buffer_if;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [3:0]  st_byte_en;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        flush;
    logic        empty;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_rdata;

    modport slave (
        input  st_valid, st_addr, st_data, st_byte_en,
        input  ld_valid, ld_addr, flush, mem_rdata,
        output st_ready, ld_data, empty,
        output mem_addr, mem_we, mem_wdata, mem_byte_en
    );

    modport master (
        output st_valid, st_addr, st_data, st_byte_en,
        output ld_valid, ld_addr, flush, mem_rdata,
        input  st_ready, ld_data, empty,
        input  mem_addr, mem_we, mem_wdata, mem_byte_en
    );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - coalescing FIFO write buffer with youngest-wins load forwarding
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic           clk,
    input  logic           reset,
    store_buffer_if.slave  bus
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [29:0]      ent_word [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [3:0]       ent_mask [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] young;
    logic [PTR_W:0]   count;

    logic full;
    logic is_empty;
    logic push;
    logic drain;
    logic coalesce;
    logic alloc;
    logic [31:0] fwd;

    assign full     = (count == FULL_CNT);
    assign is_empty = (count == '0);
    assign young    = tail - PTR_W'(1);

    assign push  = bus.st_valid & ~full & (|bus.st_byte_en);
    // Loads own the memory port; drains only use cycles with no load.
    assign drain = ~bus.ld_valid & ~is_empty;

    // Never merge into the head while it is leaving: its data is already on the bus.
    assign coalesce = push & ~is_empty
                    & (ent_word[young] == bus.st_addr[31:2])
                    & ~(drain & (young == head));
    assign alloc    = push & ~coalesce;

    assign bus.st_ready    = ~full;
    assign bus.empty       = is_empty;
    assign bus.mem_we      = drain;
    assign bus.mem_addr    = drain ? {ent_word[head], 2'b00} : bus.ld_addr;
    assign bus.mem_wdata   = ent_data[head];
    assign bus.mem_byte_en = drain ? ent_mask[head] : 4'b0000;

    // Walk oldest to youngest so later stores overwrite earlier ones byte by byte.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fwd = bus.mem_rdata;
        idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (((PTR_W+1)'(i) < count) && (ent_word[idx] == bus.ld_addr[31:2])) begin
                for (int b = 0; b < 4; b++) begin
                    if (ent_mask[idx][b]) begin
                        fwd[b*8 +: 8] = ent_data[idx][b*8 +: 8];
                    end
                end
            end
        end
    end

    assign bus.ld_data = fwd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_word[i] <= '0;
                ent_data[i] <= '0;
                ent_mask[i] <= '0;
            end
        end else begin
            if (drain) begin
                ent_mask[head] <= '0;
                head           <= head + PTR_W'(1);
            end
            if (coalesce) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus.st_byte_en[b]) begin
                        ent_data[young][b*8 +: 8] <= bus.st_data[b*8 +: 8];
                    end
                end
                ent_mask[young] <= ent_mask[young] | bus.st_byte_en;
            end else if (alloc) begin
                ent_word[tail] <= bus.st_addr[31:2];
                ent_data[tail] <= bus.st_data;
                ent_mask[tail] <= bus.st_byte_en;
                tail           <= tail + PTR_W'(1);
            end
            case ({alloc, drain})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // flush is advisory only; the consumer waits on empty.
    logic unused_ok;
    assign unused_ok = &{1'b0, bus.flush, bus.st_addr[1:0]};

endmodule
